// File: rtl/bram_client_port.sv
// Requester-side adapter for one port of a write-first block RAM.
// Issues read/write requests straight onto the RAM port, follows the fixed
// read latency with a valid shift register, and queues read data in a
// credit-protected response FIFO so that RAM output is never lost.
module bram_client_port #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int LAT = (PIPELINED != 0) ? 2 : 1;
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  // The buffer must absorb every read already launched into the RAM pipe.
  generate
    if (RESP_DEPTH < LAT + 1) begin : g_depth_check
      $error("bram_client_port: RESP_DEPTH must be at least read latency + 1");
    end
  endgenerate

  logic [CW-1:0]         credit_reg, credit_next;
  logic [CW-1:0]         occ_reg, occ_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [LAT-1:0]        inflight_reg, inflight_next;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] resp_data_reg;
  logic                  accept, rd_accept, push, pop, head_from_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Ready comes only from the registered credit count, never from resp_ready.
  assign req_ready  = (credit_reg != '0) & ~RST;
  assign accept     = req_valid & req_ready;
  assign rd_accept  = accept & ~req_write;

  assign bram_en    = accept;
  assign bram_we    = accept & req_write;
  assign bram_addr  = req_addr;
  assign bram_di    = req_data;

  assign resp_valid = (occ_reg != '0) & ~RST;
  assign resp_data  = resp_data_reg;
  assign pop        = resp_valid & resp_ready;
  assign push       = inflight_reg[LAT-1];

  // Latency tracker: stage 0 takes the new read, later stages shift along.
  assign inflight_next[0] = rd_accept;
  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
      assign inflight_next[gi] = inflight_reg[gi-1];
    end
  endgenerate

  // Next-state for credits, occupancy and pointers.
  always_comb begin
    credit_next = credit_reg;
    occ_next    = occ_reg;
    if (rd_accept && !pop) credit_next = credit_reg - CW'(1);
    else if (pop && !rd_accept) credit_next = credit_reg + CW'(1);
    if (push && !pop) occ_next = occ_reg + CW'(1);
    else if (pop && !push) occ_next = occ_reg - CW'(1);
    wr_ptr_next    = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next    = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    // Pushed word becomes the head when the FIFO is (or is about to be) empty.
    head_from_push = push && ((occ_reg == '0) || ((occ_reg == CW'(1)) && pop));
  end

  // Control state; reset discards in-flight reads and buffered responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      credit_reg   <= DEPTH_C;
      occ_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      inflight_reg <= '0;
    end else begin
      credit_reg   <= credit_next;
      occ_reg      <= occ_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      inflight_reg <= inflight_next;
    end
  end

  // Buffer storage with registered head read, forwarding a push into an empty head.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= bram_do;
    resp_data_reg <= head_from_push ? bram_do : fifo_mem[rd_ptr_next];
  end

endmodule

// File: tb/tb_bram_client_port.sv
// Bench for bram_client_port: a PIPELINED=1 instance exercised with directed
// and random traffic against a transaction-level model, plus a PIPELINED=0
// instance for the write-then-read latency case.
module tb_bram_client_port;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int L1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // pipelined instance
  logic req_valid, req_ready, req_write, resp_valid, resp_ready, bram_en, bram_we;
  logic [AW-1:0] req_addr, bram_addr;
  logic [DW-1:0] req_data, resp_data, bram_di, bram_do;

  // non-pipelined instance
  logic req_valid0, req_ready0, req_write0, resp_valid0, resp_ready0, bram_en0, bram_we0;
  logic [AW-1:0] req_addr0, bram_addr0;
  logic [DW-1:0] req_data0, resp_data0, bram_di0, bram_do0;

  bram_client_port #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do)
  );

  bram_client_port #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut0 (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_data(req_data0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0),
    .bram_en(bram_en0), .bram_we(bram_we0), .bram_addr(bram_addr0),
    .bram_di(bram_di0), .bram_do(bram_do0)
  );

  // write-first RAM port models; the pipelined one has an output register
  logic [DW-1:0] ram1 [16];
  logic [DW-1:0] raw1, pipe1;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        ram1[bram_addr] <= bram_di;
        raw1 <= bram_di;
      end else begin
        raw1 <= ram1[bram_addr];
      end
    end
    pipe1 <= raw1;
  end
  assign bram_do = pipe1;

  logic [DW-1:0] ram0 [16];
  logic [DW-1:0] raw0;
  always @(posedge clk) begin
    if (bram_en0) begin
      if (bram_we0) begin
        ram0[bram_addr0] <= bram_di0;
        raw0 <= bram_di0;
      end else begin
        raw0 <= ram0[bram_addr0];
      end
    end
  end
  assign bram_do0 = raw0;

  // reference model: shadow memory plus queue of outstanding reads
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] mem_ref [16];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int n_acc, n_pop, first_acc, first_pop, last_pop;
  int we0_cnt, rd0_cycle, rv0_cycle;
  logic [DW-1:0] data0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample just after inputs settle, check, update model, advance
  task automatic cyc();
    logic exp_ready, exp_valid, acc;
    int   sum;
    #1;
    exp_ready = !rst && (q.size() < DEPTH);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = req_valid && exp_ready;
    chk("bram_en", 32'(bram_en), 32'(acc));
    chk("bram_we", 32'(bram_we), 32'(acc && req_write));
    exp_valid = !rst && (q.size() > 0) && (q[0].avail <= cyc_n);
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) chk("resp_data", 32'(resp_data), 32'(q[0].data));
    if (!rst) begin
      sum = int'(dut.credit_reg) + int'(dut.occ_reg) + $countones(dut.inflight_reg);
      chk("credit_sum", 32'(sum), 32'(DEPTH));
      chk("no_overflow", 32'(int'(dut.occ_reg) <= DEPTH), 32'd1);
    end
    if (rst) begin
      q.delete();
    end else begin
      if (exp_valid && resp_ready) begin
        $display("cycle %0d: response data=%02h", cyc_n, q[0].data);
        void'(q.pop_front());
        n_pop++;
        if (first_pop < 0) first_pop = cyc_n;
        last_pop = cyc_n;
      end
      if (acc) begin
        if (req_write) begin
          mem_ref[req_addr] = req_data;
        end else begin
          q.push_back('{mem_ref[req_addr], cyc_n + L1 + 1});
          n_acc++;
          if (first_acc < 0) first_acc = cyc_n;
        end
      end
    end
    if (bram_we0) we0_cnt++;
    if (bram_en0 && !bram_we0 && rd0_cycle < 0) rd0_cycle = cyc_n;
    if (resp_valid0 && rv0_cycle < 0) begin
      rv0_cycle = cyc_n;
      data0 = resp_data0;
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    n_acc = 0; n_pop = 0; first_acc = -1; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b1;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_data0 = '0; resp_ready0 = 1'b1;
    we0_cnt = 0; rd0_cycle = -1; rv0_cycle = -1; data0 = '0;
    clear_stats();
    @(negedge clk);

    // reset held two cycles with a request offered
    cyc(); cyc();
    rst = 1'b0; req_valid = 1'b0;
    cyc();

    // non-pipelined: write 0xA5 to addr 3, read it back next cycle
    we0_cnt = 0;
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 4'd3; req_data0 = 8'hA5;
    cyc();
    req_write0 = 1'b0;
    cyc();
    req_valid0 = 1'b0;
    repeat (5) cyc();
    chk("np_we_pulses", 32'(we0_cnt), 32'd1);
    chk("np_latency", 32'(rv0_cycle - rd0_cycle), 32'd2);
    chk("np_data", 32'(data0), 32'hA5);

    // preload all addresses with 0x10+addr through the port
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(i); req_data = DW'(8'h10 + i);
      cyc();
    end

    // back-to-back reads of 0..7 with resp_ready high
    clear_stats();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i);
      cyc();
    end
    req_valid = 1'b0;
    repeat (6) cyc();
    chk("b2b_accepts", 32'(n_acc), 32'd8);
    chk("b2b_pops", 32'(n_pop), 32'd8);
    chk("b2b_first_lat", 32'(first_pop - first_acc), 32'd3);
    chk("b2b_consecutive", 32'(last_pop - first_pop), 32'd7);

    // backpressure: continuous reads with resp_ready low
    clear_stats();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'($urandom_range(15));
    repeat (8) cyc();
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_occupancy", 32'(dut.occ_reg), 32'd4);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    clear_stats();
    repeat (4) cyc();
    chk("bp_one_more", 32'(n_acc), 32'd1);
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (8) cyc();

    // alternating writes/reads, random addresses, data and backpressure
    for (int i = 0; i < 300; i++) begin
      req_valid  = ($urandom_range(3) != 0);
      req_write  = ((i % 2) == 0);
      req_addr   = AW'($urandom_range(15));
      req_data   = DW'($urandom);
      resp_ready = ($urandom_range(2) != 0);
      cyc();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (10) cyc();

    // reset with two reads in flight and one buffered
    resp_ready = 1'b0; req_write = 1'b0; req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_addr = AW'(i);
      cyc();
    end
    req_valid = 1'b0;
    chk("mid_buffered", 32'(dut.occ_reg), 32'd1);
    chk("mid_inflight", 32'($countones(dut.inflight_reg)), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_credits", 32'(dut.credit_reg), 32'd4);
    resp_ready = 1'b1;
    repeat (6) cyc();
    clear_stats();
    req_valid = 1'b1; req_addr = 4'd5;
    cyc();
    req_valid = 1'b0;
    repeat (6) cyc();
    chk("post_rst_pops", 32'(n_pop), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
